// File: rtl/calculate_seq_locked.sv
// Key-locked multi-cycle calculator with an HLS ap_start/ap_done handshake and a serially loaded key.
// Optional unsigned restoring divide on op 8 when CALCULATE_SEQ_DIV_EN is defined.
module calculate_seq_locked #(
  parameter int               DATA_W     = 32,
  parameter int               KEY_W      = 64,
  parameter logic [KEY_W-1:0] GOLDEN_KEY = 64'hCAAAAA82AAA957F4
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              key_load,
  input  logic              key_bit,
  output logic [DATA_W-1:0] ap_return,
  output logic              op_err
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t            state;
  logic [KEY_W-1:0]  key_reg;
  logic [DATA_W-1:0] a_reg, b_reg, acc;
  logic [3:0]        op_reg;
  logic [SH_W-1:0]   cnt;

  logic [DATA_W-1:0] mask, single_res, mul_next;
  logic              illegal, is_mul, is_div, cnt_done;
  logic              key_unused;

  assign mask       = key_reg[DATA_W-1:0] ^ GOLDEN_KEY[DATA_W-1:0];
  assign key_unused = ^key_reg;
  assign is_mul     = (op_reg == 4'd2);
  assign cnt_done   = (cnt == CNT_LAST);
  assign mul_next   = acc + (b_reg[0] ? a_reg : '0);

  assign ap_idle  = (state == S_IDLE);
  assign ap_ready = ap_idle && ap_start;
  assign ap_done  = (state == S_DONE);

`ifdef CALCULATE_SEQ_DIV_EN
  // Restoring divide: acc holds the remainder, a_reg shifts dividend out and quotient in.
  logic [DATA_W:0]   rem_sh, diff;
  logic              q_bit;
  logic [DATA_W-1:0] quo_next;
  assign is_div   = (op_reg == 4'd8);
  assign rem_sh   = {acc, a_reg[DATA_W-1]};
  assign diff     = rem_sh - {1'b0, b_reg};
  assign q_bit    = ~diff[DATA_W];
  assign quo_next = {a_reg[DATA_W-2:0], q_bit};
`else
  assign is_div = 1'b0;
`endif

  always_comb begin
    single_res = '0;
    illegal    = 1'b0;
    case (op_reg)
      4'd0:    single_res = a_reg + b_reg;
      4'd1:    single_res = a_reg - b_reg;
      4'd2:    single_res = '0;
      4'd3:    single_res = a_reg & b_reg;
      4'd4:    single_res = a_reg | b_reg;
      4'd5:    single_res = a_reg ^ b_reg;
      4'd6:    single_res = a_reg << b_reg[SH_W-1:0];
      4'd7:    single_res = {{(DATA_W-1){1'b0}}, (a_reg < b_reg)};
`ifdef CALCULATE_SEQ_DIV_EN
      4'd8:    single_res = '0;
`endif
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= S_IDLE;
      key_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      op_reg    <= '0;
      cnt       <= '0;
      ap_return <= '0;
      op_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_load) key_reg <= {key_reg[KEY_W-2:0], key_bit};
          if (ap_start) begin
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= op;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mul) begin
            acc   <= mul_next;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + 1'b1;
            if (cnt_done) begin
              ap_return <= mul_next ^ mask;
              op_err    <= 1'b0;
              state     <= S_DONE;
            end
          end else if (is_div) begin
`ifdef CALCULATE_SEQ_DIV_EN
            acc   <= q_bit ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
            a_reg <= quo_next;
            cnt   <= cnt + 1'b1;
            if (cnt_done) begin
              ap_return <= quo_next ^ mask;
              op_err    <= 1'b0;
              state     <= S_DONE;
            end
`endif
          end else begin
            // mask is applied even to illegal ops, so a wrong key also shows up here
            ap_return <= single_res ^ mask;
            op_err    <= illegal;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calculate_seq_locked.sv
// Directed bench for calculate_seq_locked: vector table plus hand sequences for key, reset and handshake corners.
module tb_calculate_seq_locked;

  localparam logic [63:0] GOLDEN = 64'hCAAAAA82AAA957F4;

  logic        ap_clk = 1'b0;
  logic        ap_rst, ap_start, ap_done, ap_idle, ap_ready;
  logic [3:0]  op;
  logic [31:0] a, b, ap_return;
  logic        key_load, key_bit, op_err;

  int tests = 0;
  int fails = 0;

  always #5 ap_clk = ~ap_clk;

  calculate_seq_locked dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .op(op), .a(a), .b(b),
    .key_load(key_load), .key_bit(key_bit), .ap_return(ap_return), .op_err(op_err)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ret;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
  endtask

  task automatic load_key(input logic [63:0] k);
    for (int i = 63; i >= 0; i--) begin
      @(posedge ap_clk); #1;
      key_load = 1'b1;
      key_bit  = k[i];
    end
    @(posedge ap_clk); #1;
    key_load = 1'b0;
  endtask

  // Returns in the cycle ap_done is seen (or after the cycle budget), #1 past the edge.
  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (ap_done !== 1'b1 && lat < 100) begin
      @(posedge ap_clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] ret, output logic err, output int lat);
    @(posedge ap_clk); #1;
    ap_start = 1'b1; op = o; a = x; b = y;
    #1 check("ap_ready_on_accept", {31'b0, ap_ready}, 32'd1);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    wait_done(1, lat);
    ret = ap_return;
    err = op_err;
  endtask

  task automatic add_vec(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic e, input int l);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.ret = r; v.err = e; v.lat = l;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ret;
    logic        err;
    int          lat;
    int          dones;

    ap_rst = 1'b0; ap_start = 1'b0; op = '0; a = '0; b = '0;
    key_load = 1'b0; key_bit = 1'b0;

    // golden key loaded -> zero mask, results are raw
    add_vec(4'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 2);
    add_vec(4'd1, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 2);
    add_vec(4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 2);
    add_vec(4'd4, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, 1'b0, 2);
    add_vec(4'd5, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 2);
    add_vec(4'd6, 32'h1,        32'd31,       32'h80000000, 1'b0, 2);
    add_vec(4'd6, 32'h3,        32'h21,       32'h6,        1'b0, 2);
    add_vec(4'd7, 32'h2,        32'hFFFFFFFF, 32'h1,        1'b0, 2);
    add_vec(4'd7, 32'h5,        32'h5,        32'h0,        1'b0, 2);
    add_vec(4'd2, 32'h00010003, 32'h7,        32'h00070015, 1'b0, 33);
    add_vec(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 33);
    add_vec(4'd2, 32'd12345,    32'h0,        32'h0,        1'b0, 33);
    add_vec(4'd12, 32'h5,       32'h3,        32'h0,        1'b1, 2);
    add_vec(4'd9,  32'h5,       32'h3,        32'h0,        1'b1, 2);
    add_vec(4'd15, 32'h5,       32'h3,        32'h0,        1'b1, 2);
`ifdef CALCULATE_SEQ_DIV_EN
    add_vec(4'd8, 32'd100,      32'd7,        32'd14,       1'b0, 33);
    add_vec(4'd8, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b0, 33);
`else
    add_vec(4'd8, 32'd100,      32'd7,        32'h0,        1'b1, 2);
`endif

    do_reset();
    check("reset_idle",   {31'b0, ap_idle},  32'd1);
    check("reset_done",   {31'b0, ap_done},  32'd0);
    check("reset_ready",  {31'b0, ap_ready}, 32'd0);
    check("reset_return", ap_return,         32'd0);
    check("reset_err",    {31'b0, op_err},   32'd0);

    // no key: mask is the low half of the golden key
    run_op(4'd0, 32'd5, 32'd3, ret, err, lat);
    check("nokey_add_ret", ret, 32'hAAA957FC);
    check("nokey_add_err", {31'b0, err}, 32'd0);
    check("nokey_add_lat", lat, 32'd2);

    load_key(GOLDEN);
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, ret, err, lat);
      check($sformatf("vec%0d_op%0d_ret", i, vecs[i].op), ret, vecs[i].ret);
      check($sformatf("vec%0d_op%0d_err", i, vecs[i].op), {31'b0, err}, {31'b0, vecs[i].err});
      check($sformatf("vec%0d_op%0d_lat", i, vecs[i].op), lat, vecs[i].lat);
    end

    // held ap_start: ignored in DONE, accepted in the next IDLE cycle
    @(posedge ap_clk); #1;
    ap_start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd2;
    @(posedge ap_clk); #1;
    wait_done(1, lat);
    check("held_first_ret", ap_return, 32'd3);
    check("held_ready_in_done", {31'b0, ap_ready}, 32'd0);
    @(posedge ap_clk); #1;
    check("held_ready_next_idle", {31'b0, ap_ready}, 32'd1);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    wait_done(1, lat);
    check("held_second_lat", lat, 32'd2);

    // key_load during a multiply must not disturb the key
    @(posedge ap_clk); #1;
    ap_start = 1'b1; op = 4'd2; a = 32'h00010003; b = 32'h7;
    @(posedge ap_clk); #1;
    ap_start = 1'b0; key_load = 1'b1; key_bit = 1'b1;
    repeat (5) @(posedge ap_clk);
    #1 key_load = 1'b0;
    wait_done(6, lat);
    check("keyfrozen_mul_ret", ap_return, 32'h00070015);
    check("keyfrozen_mul_lat", lat, 32'd33);
    run_op(4'd12, 32'd0, 32'd0, ret, err, lat);
    check("keyfrozen_mask", ret, 32'h0);

    // wrong key in the lowest bit flips the result's lowest bit
    do_reset();
    load_key(GOLDEN ^ 64'h1);
    run_op(4'd0, 32'd2, 32'd2, ret, err, lat);
    check("wrongkey_add_ret", ret, 32'd5);

    // reset during the 10th EXEC cycle of a multiply
    run_op(4'd0, 32'd1, 32'd2, ret, err, lat);
    run_op(4'd13, 32'd0, 32'd0, ret, err, lat);
    check("prereset_err", {31'b0, err}, 32'd1);
    @(posedge ap_clk); #1;
    ap_start = 1'b1; op = 4'd2; a = 32'd3; b = 32'd3;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (9) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    check("midrst_idle",   {31'b0, ap_idle}, 32'd1);
    check("midrst_done",   {31'b0, ap_done}, 32'd0);
    check("midrst_return", ap_return,        32'd0);
    check("midrst_err",    {31'b0, op_err},  32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge ap_clk); #1;
      if (ap_done === 1'b1) dones++;
    end
    check("midrst_no_done", dones, 32'd0);
    run_op(4'd12, 32'd0, 32'd0, ret, err, lat);
    check("midrst_key_cleared", ret, 32'hAAA957F4);
    check("midrst_illegal_err", {31'b0, err}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calculate_seq_locked.md
Name: calculate_seq_locked

Overview:
- Parametrised, multi-cycle successor to the single-operation locked calculator.
- Runs one of several arithmetic/logic operations per transaction, using the HLS block-level handshake (ap_start/ap_done/ap_idle/ap_ready).
- The locking key is held in an internal register loaded serially, instead of being a static port. A wrong key deterministically corrupts every result.
- Sits behind the accelerator wrapper layer, alongside the obfuscated calculate blocks.

Parameters:
- DATA_W, 32, operand and result width (≥4, power of 2).
- KEY_W, 64, key register width (must be ≥ DATA_W).
- GOLDEN_KEY, 64'hCAAAAA82AAA957F4, correct key value.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  synchronous, active-high reset.
- ap_start  in  1  transaction request.
- ap_done  out  1  one-cycle pulse; ap_return/op_err valid.
- ap_idle  out  1  block in IDLE.
- ap_ready  out  1  operands consumed this cycle.
- op  in  4  operation select.
- a  in  DATA_W  operand A.
- b  in  DATA_W  operand B.
- key_load  in  1  shift enable for the key register.
- key_bit  in  1  serial key bit, MSB first.
- ap_return  out  DATA_W  registered result.
- op_err  out  1  registered; illegal opcode flag for the current result.

Behaviour:
- Reset (ap_rst=1 at posedge, any state, including mid-operation):
  - state returns to IDLE.
  - key_reg, ap_return and op_err cleared to 0.
  - All internal operand and accumulator registers cleared.
  - ap_done=0 after reset.
- States: IDLE, EXEC, DONE.
- IDLE:
  - ap_idle=1.
  - ap_ready = ap_start (combinational).
  - On ap_start=1, capture a, b and op, then go to EXEC.
- EXEC, single-cycle ops, 1 cycle then DONE:
  - 0 add, 1 sub (a-b), 3 and, 4 or, 5 xor.
  - 6 shl: a << b[log2(DATA_W)-1:0].
  - 7 ltu: result 1 if a<b unsigned, else 0.
- EXEC, op 2 mul:
  - Shift-add multiply, exactly DATA_W cycles, then DONE.
  - Result is the low DATA_W bits of the product.
- Illegal ops (9-15; also 8 when the optional feature is out): 1 EXEC cycle; raw result 0; op_err=1.
- Arithmetic wraps modulo 2^DATA_W. No carry-out or overflow flag.
- DATA_W-cycle ops use an internal counter; the final count value is DATA_W-1.
- DONE:
  - ap_done=1 for exactly one cycle. ap_return and op_err are updated on the clock edge entering DONE.
  - Next state is IDLE unconditionally; a held ap_start is accepted in the following IDLE cycle.
  - ap_return and op_err hold their values until the next DONE.
- Latency, from the start-accept edge to the ap_done cycle:
  - 2 cycles for single-cycle ops.
  - DATA_W+1 cycles for mul/div.
  - Back-to-back transaction spacing is therefore latency+1.
- Locking:
  - ap_return = raw_result XOR mask, where mask = (key_reg XOR GOLDEN_KEY)[DATA_W-1:0], sampled when the result is registered.
  - op_err is never masked.
- Key load:
  - In IDLE, key_load=1 shifts key_reg <= {key_reg[KEY_W-2:0], key_bit}.
  - key_load outside IDLE is ignored, so the key is frozen during a transaction.
  - key_load and ap_start in the same IDLE cycle: both take effect; the transaction uses the shifted key.
- ap_ready is never asserted outside IDLE. ap_start outside IDLE is ignored.

Optional Feature:
- Macro: CALCULATE_SEQ_DIV_EN.
- Defined:
  - op 8 is unsigned restoring division a/b, DATA_W EXEC cycles, result is the quotient.
  - b=0 gives an all-ones quotient, op_err=0.
- Not defined:
  - op 8 is illegal: raw result 0, op_err=1, 1 EXEC cycle.
  - No divider logic is synthesised.

Test Plan:
- Reset, no key loaded, op=0, a=5, b=3: ap_ready=1 on the accept cycle; ap_done 2 cycles later; ap_return=0xAAA957FC; op_err=0.
- Shift in GOLDEN_KEY (64 key_load cycles, MSB first), then op=2, a=0x00010003, b=0x00000007: ap_done exactly 33 cycles after accept; ap_return=0x00070015.
- With the golden key loaded, op=1, a=0, b=1: ap_return=0xFFFFFFFF. Then op=7, a=2, b=0xFFFFFFFF: ap_return=1.
- op=12: op_err=1 and ap_return=mask (0 with the golden key). Pulse key_load during a mul: key_reg unchanged, result still correct.
- Assert ap_rst in the 10th EXEC cycle of a mul: next cycle state IDLE, ap_idle=1, ap_return=0, key_reg=0, no ap_done pulse.
- With CALCULATE_SEQ_DIV_EN and the golden key: op=8, a=100, b=7 gives 14 after DATA_W+1 cycles; b=0 gives 0xFFFFFFFF. Without the macro: op=8 gives op_err=1.
